axi4_lite_slave_read_state: RTL and testbench

AXI4-Lite slave read-channel responder: the downstream peer of the master read state machine, consuming its ARVALID/RREADY and returning ARREADY/RVALID with data. It accepts one read address at a time, decodes it against a local register window, and issues a single-cycle read strobe to a register bank with fixed read latency. It returns RDATA/RRESP on the R channel and holds them until the master accepts them. There is no outstanding-transaction overlap.

---
 rtl/axi4_lite_pkg.sv | 5 +
 rtl/axi4_lite_slave_addr_decode.sv | 25 ++
 rtl/axi4_lite_slave_read_state.sv | 111 +++++++++++
 tb/tb_axi4_lite_slave_read_state.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared AXI4-Lite response codes and slave read state encoding
package axi4_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {IDLE, LOCAL_RD, RESP} rd_slv_state_t;
endpackage

// File: rtl/axi4_lite_slave_addr_decode.sv
// axi4_lite_slave_addr_decode: maps a byte address and protection bits onto the local register window
module axi4_lite_slave_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int NUM_REGS = 16,
  parameter int SECURE_ONLY = 0
) (
  input  logic [ADDR_WIDTH-1:0]       araddr,
  input  logic [2:0]                  arprot,
  output logic                        in_range,
  output logic                        prot_err,
  output logic [$clog2(NUM_REGS)-1:0] reg_index
);
  localparam int BW = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] WIN = ADDR_WIDTH'(NUM_REGS * (DATA_WIDTH / 8));
  logic [ADDR_WIDTH-1:0] offset;
  logic unused_prot;
  assign offset = araddr - BASE_ADDR;
  assign in_range = offset < WIN;
  assign prot_err = in_range && (SECURE_ONLY != 0) && arprot[1];
  assign reg_index = offset[BW +: IW];
  assign unused_prot = ^{arprot[2], arprot[0]};
endmodule

// File: rtl/axi4_lite_slave_read_state.sv
// axi4_lite_slave_read_state: AXI4-Lite read responder fronting a fixed-latency register bank
module axi4_lite_slave_read_state
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int NUM_REGS = 16,
  parameter int RD_LATENCY = 1,
  parameter int SECURE_ONLY = 0
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  input  logic [ADDR_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                  ARPROT,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [DATA_WIDTH-1:0]       RDATA,
  output logic [1:0]                  RRESP,
  output logic                        REG_RE,
  output logic [$clog2(NUM_REGS)-1:0] REG_ADDR,
  input  logic [DATA_WIDTH-1:0]       REG_RDATA,
  input  logic                        REG_RERR
);
  localparam int IW = $clog2(NUM_REGS);
  rd_slv_state_t state_q, state_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, reg_re_q, reg_re_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t rresp_q, rresp_d;
  logic [IW-1:0] reg_addr_q, reg_addr_d, reg_index;
  logic [2:0] cnt_q, cnt_d;
  logic in_range, prot_err, hs_ar, hs_r, go;
  axi4_lite_slave_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BASE_ADDR(BASE_ADDR),
    .NUM_REGS(NUM_REGS), .SECURE_ONLY(SECURE_ONLY)
  ) u_dec (
    .araddr(ARADDR), .arprot(ARPROT), .in_range(in_range), .prot_err(prot_err), .reg_index(reg_index)
  );
  assign hs_ar = ARVALID & arready_q;
  assign hs_r = rvalid_q & RREADY;
  assign go = hs_ar & in_range & ~prot_err;
  always_comb begin
    state_d = state_q;
    arready_d = arready_q;
    rvalid_d = rvalid_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    reg_re_d = 1'b0;
    reg_addr_d = reg_addr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        arready_d = ~hs_ar;
        if (hs_ar) begin
          state_d = go ? LOCAL_RD : RESP;
          rdata_d = '0;
          rresp_d = !in_range ? DECERR : prot_err ? SLVERR : OKAY;
          reg_re_d = go;
          reg_addr_d = go ? reg_index : reg_addr_q;
          cnt_d = 3'(RD_LATENCY);
        end
      end
      LOCAL_RD: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          rdata_d = REG_RDATA;
          rresp_d = REG_RERR ? SLVERR : OKAY;
          rvalid_d = 1'b1;
        end
      end
      RESP: begin
        rvalid_d = ~hs_r;
        arready_d = hs_r;
        state_d = hs_r ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= OKAY;
      reg_re_q <= 1'b0;
      reg_addr_q <= '0;
      cnt_q <= '0;
    end else begin
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      reg_re_q <= reg_re_d;
      reg_addr_q <= reg_addr_d;
      cnt_q <= cnt_d;
    end
  end
  assign ARREADY = arready_q;
  assign RVALID = rvalid_q;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  assign REG_RE = reg_re_q;
  assign REG_ADDR = reg_addr_q;
endmodule

// File: tb/tb_axi4_lite_slave_read_state.sv
// tb_axi4_lite_slave_read_state: directed checks of three responder configurations against a latency-modelled bank
module tb_axi4_lite_slave_read_state;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic [31:0] bank [16];
  logic arvalid0 = 0, rready0 = 0, arready0, rvalid0, reg_re0;
  logic [31:0] araddr0 = 0, rdata0, reg_rdata0;
  logic [2:0] arprot0 = 0, v0 = '0;
  logic [1:0] rresp0;
  logic [3:0] reg_addr0;
  logic reg_rerr0;
  logic arvalid1 = 0, rready1 = 0, arready1, rvalid1, reg_re1, err1 = 0;
  logic [31:0] araddr1 = 0, rdata1, reg_rdata1;
  logic [2:0] arprot1 = 0, v1 = '0;
  logic [1:0] rresp1;
  logic [3:0] reg_addr1;
  logic reg_rerr1;
  logic arvalid2 = 0, rready2 = 0, arready2, rvalid2, reg_re2;
  logic [31:0] araddr2 = 0, rdata2, reg_rdata2;
  logic [2:0] arprot2 = 0, v2 = '0;
  logic [1:0] rresp2;
  logic [3:0] reg_addr2;
  logic reg_rerr2;
  always @(posedge clk) begin
    v0 <= {v0[1:0], reg_re0};
    v1 <= {v1[1:0], reg_re1};
    v2 <= {v2[1:0], reg_re2};
  end
  assign reg_rdata0 = v0[0] ? bank[reg_addr0] : 32'hBAD0_BAD0;
  assign reg_rerr0 = 1'b0;
  assign reg_rdata1 = v1[2] ? bank[reg_addr1] : 32'hBAD0_BAD0;
  assign reg_rerr1 = v1[2] & err1;
  assign reg_rdata2 = v2[0] ? bank[reg_addr2] : 32'hBAD0_BAD0;
  assign reg_rerr2 = 1'b0;
  axi4_lite_slave_read_state u0 (
    .ACLK(clk), .ARESETn(rstn), .ARVALID(arvalid0), .ARREADY(arready0), .ARADDR(araddr0), .ARPROT(arprot0),
    .RVALID(rvalid0), .RREADY(rready0), .RDATA(rdata0), .RRESP(rresp0), .REG_RE(reg_re0), .REG_ADDR(reg_addr0),
    .REG_RDATA(reg_rdata0), .REG_RERR(reg_rerr0));
  axi4_lite_slave_read_state #(.RD_LATENCY(3)) u1 (
    .ACLK(clk), .ARESETn(rstn), .ARVALID(arvalid1), .ARREADY(arready1), .ARADDR(araddr1), .ARPROT(arprot1),
    .RVALID(rvalid1), .RREADY(rready1), .RDATA(rdata1), .RRESP(rresp1), .REG_RE(reg_re1), .REG_ADDR(reg_addr1),
    .REG_RDATA(reg_rdata1), .REG_RERR(reg_rerr1));
  axi4_lite_slave_read_state #(.SECURE_ONLY(1)) u2 (
    .ACLK(clk), .ARESETn(rstn), .ARVALID(arvalid2), .ARREADY(arready2), .ARADDR(araddr2), .ARPROT(arprot2),
    .RVALID(rvalid2), .RREADY(rready2), .RDATA(rdata2), .RRESP(rresp2), .REG_RE(reg_re2), .REG_ADDR(reg_addr2),
    .REG_RDATA(reg_rdata2), .REG_RERR(reg_rerr2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    n_cmp++; if ({arready0, rvalid0, reg_re0, reg_addr0, rresp0} !== 9'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0", {arready0, rvalid0, reg_re0, reg_addr0, rresp0}); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata0); end
    rstn = 1'b1;
    tick();
    n_cmp++; if ({arready0, arready1, arready2} !== 3'b111) begin n_err++; $display("FAIL reset_arready_rise: got %b want 111", {arready0, arready1, arready2}); end
  endtask
  task automatic test_basic_read();
    rready0 = 1; araddr0 = 32'h8; arvalid0 = 1;
    tick();
    arvalid0 = 0;
    n_cmp++; if ({reg_re0, reg_addr0, arready0, rvalid0} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin n_err++; $display("FAIL basic_E: got re/addr/ar/rv %b want 1001000", {reg_re0, reg_addr0, arready0, rvalid0}); end
    tick();
    n_cmp++; if ({reg_re0, rvalid0} !== 2'b00) begin n_err++; $display("FAIL basic_E1: got re/rv %b want 00", {reg_re0, rvalid0}); end
    tick();
    n_cmp++; if (rvalid0 !== 1'b1 || reg_addr0 !== 4'd2) begin n_err++; $display("FAIL basic_rvalid: got rv %b addr %0d want 1 2", rvalid0, reg_addr0); end
    n_cmp++; if (rdata0 !== 32'hDEADBEEF || rresp0 !== 2'b00) begin n_err++; $display("FAIL basic_data: got %h/%b want deadbeef/00", rdata0, rresp0); end
    tick();
    n_cmp++; if ({rvalid0, arready0} !== 2'b01) begin n_err++; $display("FAIL basic_done: got rv/ar %b want 01", {rvalid0, arready0}); end
  endtask
  task automatic test_decerr();
    araddr0 = 32'h40; arvalid0 = 1;
    tick();
    arvalid0 = 0;
    n_cmp++; if ({reg_re0, rvalid0, arready0} !== 3'b000) begin n_err++; $display("FAIL decerr_E: got re/rv/ar %b want 000", {reg_re0, rvalid0, arready0}); end
    tick();
    n_cmp++; if ({rvalid0, reg_re0, rresp0} !== 4'b1011 || rdata0 !== 32'h0) begin n_err++; $display("FAIL decerr_resp: got rv/re/resp %b data %h want 1011 0", {rvalid0, reg_re0, rresp0}, rdata0); end
    tick();
    n_cmp++; if ({rvalid0, arready0} !== 2'b01) begin n_err++; $display("FAIL decerr_done: got rv/ar %b want 01", {rvalid0, arready0}); end
  endtask
  task automatic test_latency_err();
    err1 = 1; rready1 = 0; araddr1 = 32'hC; arvalid1 = 1;
    tick();
    arvalid1 = 0;
    n_cmp++; if ({reg_re1, reg_addr1} !== {1'b1, 4'd3}) begin n_err++; $display("FAIL lat_re: got %b want 10011", {reg_re1, reg_addr1}); end
    repeat (3) tick();
    n_cmp++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL lat_early: got rvalid %b want 0", rvalid1); end
    tick();
    n_cmp++; if (rvalid1 !== 1'b1 || rresp1 !== 2'b10 || rdata1 !== bank[3]) begin n_err++; $display("FAIL lat_resp: got %b/%b/%h want 1/10/%h", rvalid1, rresp1, rdata1, bank[3]); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if ({rvalid1, arready1, rresp1} !== 4'b1010 || rdata1 !== bank[3]) begin n_err++; $display("FAIL lat_hold%0d: got rv/ar/resp %b data %h", i, {rvalid1, arready1, rresp1}, rdata1); end
    end
    rready1 = 1;
    tick();
    n_cmp++; if ({rvalid1, arready1} !== 2'b01) begin n_err++; $display("FAIL lat_done: got rv/ar %b want 01", {rvalid1, arready1}); end
    rready1 = 0; err1 = 0;
  endtask
  task automatic test_secure();
    rready2 = 1; arprot2 = 3'b010; araddr2 = 32'h4; arvalid2 = 1;
    tick();
    arvalid2 = 0;
    n_cmp++; if ({reg_re2, rvalid2} !== 2'b00) begin n_err++; $display("FAIL sec_E: got re/rv %b want 00", {reg_re2, rvalid2}); end
    tick();
    n_cmp++; if ({rvalid2, rresp2} !== 3'b110 || rdata2 !== 32'h0) begin n_err++; $display("FAIL sec_slverr: got rv/resp %b data %h want 110 0", {rvalid2, rresp2}, rdata2); end
    tick();
    n_cmp++; if ({rvalid2, arready2} !== 2'b01) begin n_err++; $display("FAIL sec_done: got rv/ar %b want 01", {rvalid2, arready2}); end
    arprot2 = 3'b000; arvalid2 = 1;
    tick();
    arvalid2 = 0;
    n_cmp++; if ({reg_re2, reg_addr2} !== {1'b1, 4'd1}) begin n_err++; $display("FAIL sec_ok_re: got %b want 10001", {reg_re2, reg_addr2}); end
    repeat (2) tick();
    n_cmp++; if ({rvalid2, rresp2} !== 3'b100 || rdata2 !== bank[1]) begin n_err++; $display("FAIL sec_ok_resp: got %b data %h want 100 %h", {rvalid2, rresp2}, rdata2, bank[1]); end
    tick();
    n_cmp++; if (rvalid2 !== 1'b0) begin n_err++; $display("FAIL sec_ok_done: got rvalid %b want 0", rvalid2); end
  endtask
  task automatic test_back_to_back();
    int acc[$];
    logic [31:0] got[$];
    int cyc = 0, idx = 0;
    logic hs;
    rready0 = 1; araddr0 = 32'h0; arvalid0 = 1;
    while (got.size() < 3 && cyc < 40) begin
      hs = arready0 & arvalid0;
      if (hs) acc.push_back(cyc);
      if (rvalid0 & rready0) got.push_back(rdata0);
      tick();
      cyc++;
      if (hs) begin
        idx++;
        if (idx == 3) arvalid0 = 0;
        else araddr0 = 32'(idx * 4);
      end
    end
    arvalid0 = 0;
    n_cmp++; if (acc.size() != 3 || got.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d accepts %0d beats want 3 3", acc.size(), got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (got[i] !== bank[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, got[i], bank[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++; if (acc[i] - acc[i-1] != 4) begin n_err++; $display("FAIL b2b_period%0d: got %0d want 4", i, acc[i] - acc[i-1]); end
      end
    end
    tick();
  endtask
  task automatic test_reset_mid();
    rready1 = 0; araddr1 = 32'h8; arvalid1 = 1;
    tick();
    arvalid1 = 0;
    tick();
    rstn = 0;
    tick();
    n_cmp++; if ({arready1, rvalid1, reg_re1, reg_addr1, rresp1} !== 9'b0 || rdata1 !== 32'h0) begin n_err++; $display("FAIL mid_reset: got %b data %h want 0", {arready1, rvalid1, reg_re1, reg_addr1, rresp1}, rdata1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL mid_rvalid%0d: got %b want 0", i, rvalid1); end
    end
    rstn = 1;
    tick();
    n_cmp++; if ({arready1, rvalid1} !== 2'b10) begin n_err++; $display("FAIL mid_release: got ar/rv %b want 10", {arready1, rvalid1}); end
    rready1 = 1; araddr1 = 32'h14; arvalid1 = 1;
    tick();
    arvalid1 = 0;
    repeat (4) tick();
    n_cmp++; if ({rvalid1, rresp1} !== 3'b100 || rdata1 !== bank[5]) begin n_err++; $display("FAIL mid_next: got %b data %h want 100 %h", {rvalid1, rresp1}, rdata1, bank[5]); end
    tick();
    n_cmp++; if ({rvalid1, arready1} !== 2'b01) begin n_err++; $display("FAIL mid_next_done: got rv/ar %b want 01", {rvalid1, arready1}); end
    rready1 = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) bank[i] = 32'h1000_0000 + 32'(i);
    bank[2] = 32'hDEADBEEF;
    repeat (2) tick();
    test_reset();
    test_basic_read();
    test_decerr();
    test_latency_err();
    test_secure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
